// File: rtl/fbosc_pkg.sv
// Shared definitions for the feedback-oscillator pair and its monitor.
// The state encodings are also used by the oscillator bench.
package fbosc_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACQUIRE = 2'd1;
  localparam logic [1:0] LOCKED  = 2'd2;
  localparam logic [1:0] FAULT   = 2'd3;

  typedef enum logic [1:0] {
    StIdle    = IDLE,
    StAcquire = ACQUIRE,
    StLocked  = LOCKED,
    StFault   = FAULT
  } state_e;

endpackage

// File: rtl/fbosc_monitor_if.sv
// Monitor-side bundle: control, the oscillator pair under test, and status outputs.
// Signal prefixes follow the monitor's point of view.
interface fbosc_monitor_if #(
  parameter int unsigned ERR_W = 8
) ();

  logic             i_en;
  logic             i_clr;
  logic             i_y1;
  logic             i_y2;
  logic             o_locked;
  logic             o_fault;
  logic [ERR_W-1:0] o_err_cnt;
  logic [1:0]       o_state;

  modport master (
    output i_en, i_clr, i_y1, i_y2,
    input  o_locked, o_fault, o_err_cnt, o_state
  );

  modport slave (
    input  i_en, i_clr, i_y1, i_y2,
    output o_locked, o_fault, o_err_cnt, o_state
  );

endinterface

// File: rtl/fbosc_pair_chk.sv
// Samples the oscillator pair and judges each sampled cycle as good or bad.
// No verdict is given until two samples have been taken after reset.
module fbosc_pair_chk (
  input  logic clk,
  input  logic rst_n,
  input  logic i_y1,
  input  logic i_y2,
  output logic o_good,
  output logic o_bad
);

  logic r_y1_q;
  logic r_y2_q;
  logic r_y1_p;
  logic r_pv0;
  logic r_pv;
  logic w_good;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y1_q <= 1'b0;
      r_y2_q <= 1'b0;
      r_y1_p <= 1'b0;
      r_pv0  <= 1'b0;
      r_pv   <= 1'b0;
    end else begin
      r_y1_q <= i_y1;
      r_y2_q <= i_y2;
      r_y1_p <= r_y1_q;
      r_pv0  <= 1'b1;
      r_pv   <= r_pv0;
    end
  end

  // Good: outputs complementary and y1 changed since the previous sample.
  assign w_good = r_pv & (r_y1_q ^ r_y2_q) & (r_y1_q ^ r_y1_p);
  assign o_good = w_good;
  assign o_bad  = r_pv & ~w_good;

endmodule

// File: rtl/fbosc_monitor.sv
// Lock/fault tracker for the two-flop feedback oscillator pair.
// Acquires lock after LOCK_CNT good cycles, counts glitches, faults on MAX_MISS misses.
module fbosc_monitor
  import fbosc_pkg::*;
#(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned MAX_MISS = 2,
  parameter int unsigned ERR_W    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  fbosc_monitor_if.slave  bus
);

  localparam int unsigned RunW  = $clog2(LOCK_CNT + 1);
  localparam int unsigned MissW = $clog2(MAX_MISS + 1);
  localparam logic [RunW-1:0]  RunLast  = RunW'(LOCK_CNT - 1);
  localparam logic [MissW-1:0] MissLast = MissW'(MAX_MISS - 1);

  state_e           r_state, w_state_d;
  logic [RunW-1:0]  r_run, w_run_d;
  logic [MissW-1:0] r_miss, w_miss_d;
  logic [ERR_W-1:0] r_err, w_err_d;
  logic             r_locked, w_locked_d;
  logic             r_fault, w_fault_d;
  logic             w_good;
  logic             w_bad;

  fbosc_pair_chk u_pair_chk (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_y1   (bus.i_y1),
    .i_y2   (bus.i_y2),
    .o_good (w_good),
    .o_bad  (w_bad)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_run    <= '0;
      r_miss   <= '0;
      r_err    <= '0;
      r_locked <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_run    <= w_run_d;
      r_miss   <= w_miss_d;
      r_err    <= w_err_d;
      r_locked <= w_locked_d;
      r_fault  <= w_fault_d;
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_run_d    = r_run;
    w_miss_d   = r_miss;
    w_err_d    = r_err;
    w_locked_d = r_locked;
    w_fault_d  = r_fault;

    if (!bus.i_en) begin
      // Disable wins over everything; error count and fault flag are kept.
      w_state_d  = StIdle;
      w_locked_d = 1'b0;
      w_run_d    = '0;
      w_miss_d   = '0;
    end else if (bus.i_clr) begin
      // Clear suppresses the normal transition on this edge.
      w_err_d = '0;
      if (r_state == StFault) begin
        w_state_d = StAcquire;
        w_run_d   = '0;
        w_fault_d = 1'b0;
      end
    end else begin
      unique case (r_state)
        StIdle: begin
          w_state_d = StAcquire;
          w_run_d   = '0;
        end
        StAcquire: begin
          if (w_good) begin
            if (r_run == RunLast) begin
              w_state_d  = StLocked;
              w_locked_d = 1'b1;
              w_miss_d   = '0;
              w_run_d    = '0;
            end else begin
              w_run_d = r_run + RunW'(1);
            end
          end else if (w_bad) begin
            w_run_d = '0;
          end
        end
        StLocked: begin
          if (w_good) begin
            w_miss_d = '0;
          end else if (w_bad) begin
            if (r_err != '1) begin
              w_err_d = r_err + ERR_W'(1);
            end
            if (r_miss == MissLast) begin
              w_state_d  = StFault;
              w_fault_d  = 1'b1;
              w_locked_d = 1'b0;
              w_miss_d   = '0;
            end else begin
              w_miss_d = r_miss + MissW'(1);
            end
          end
        end
        StFault: begin
          w_locked_d = 1'b0;
          w_fault_d  = 1'b1;
        end
        default: begin
          w_state_d = StIdle;
        end
      endcase
    end
  end

  assign bus.o_locked  = r_locked;
  assign bus.o_fault   = r_fault;
  assign bus.o_err_cnt = r_err;
  assign bus.o_state   = r_state;

endmodule
